// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Queues ALU commands and issues them one at a time to the ALU.
//            Returns each captured result with its opcode and tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_issuer #(
  parameter int DW    = 4,
  parameter int OPW   = 3,
  parameter int RW    = 8,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  // command port
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_opcode,
  input  logic [DW-1:0]  cmd_op1,
  input  logic [DW-1:0]  cmd_op2,
  input  logic [1:0]     cmd_tag,
  // ALU side
  output logic [OPW-1:0] OPCODE,
  output logic [DW-1:0]  OP1,
  output logic [DW-1:0]  OP2,
  input  logic [RW-1:0]  alu_result,
  // response port
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [RW-1:0]  rsp_result,
  output logic [OPW-1:0] rsp_opcode,
  output logic [1:0]     rsp_tag,
  // status
  output logic           busy,
  output logic [7:0]     op_count
);

  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_WCW = (LAT < 2) ? 1 : $clog2(LAT);
  localparam int c_EW  = OPW + 2 * DW + 2;

  localparam logic [c_AW:0]    c_FULL      = (c_AW + 1)'(DEPTH);
  localparam logic [c_WCW-1:0] c_WAIT_INIT = (LAT == 0) ? '0 : c_WCW'(LAT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [c_EW-1:0] w_head;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  // Ready comes only from the registered count, so a same-cycle pop never raises it.
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_op1, cmd_op2, cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             w_capture;

  logic [OPW-1:0]   r_opcode;
  logic [DW-1:0]    r_op1;
  logic [DW-1:0]    r_op2;
  logic [1:0]       r_tag;
  logic [c_WCW-1:0] r_wait_cnt;

  logic [RW-1:0]    r_rsp_result;
  logic [OPW-1:0]   r_rsp_opcode;
  logic [1:0]       r_rsp_tag;
  logic [7:0]       r_op_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = c_ISSUE;
        end
      end
      c_ISSUE: begin
        if (LAT == 0) begin
          w_capture    = 1'b1;
          w_next_state = c_RESP;
        end else begin
          w_next_state = c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = c_RESP;
        end
      end
      c_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = c_ISSUE;
          end else begin
            w_next_state = c_IDLE;
          end
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    OPCODE    = '0;
    OP1       = '0;
    OP2       = '0;
    rsp_valid = (r_state == c_RESP);
    busy      = (r_state != c_IDLE) || !w_empty;
    if ((r_state == c_ISSUE) || (r_state == c_WAIT)) begin
      OPCODE = r_opcode;
      OP1    = r_op1;
      OP2    = r_op2;
    end
  end

  // --------------------------------------------------------------------------
  // Operand, wait counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_opcode     <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_tag        <= '0;
      r_wait_cnt   <= '0;
      r_rsp_result <= '0;
      r_rsp_opcode <= '0;
      r_rsp_tag    <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_pop) begin
        {r_opcode, r_op1, r_op2, r_tag} <= w_head;
      end
      if (r_state == c_ISSUE) begin
        r_wait_cnt <= c_WAIT_INIT;
      end else if ((r_state == c_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_result <= alu_result;
        r_rsp_opcode <= r_opcode;
        r_rsp_tag    <= r_tag;
      end
      if ((r_state == c_RESP) && rsp_ready) begin
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_opcode = r_rsp_opcode;
  assign rsp_tag    = r_rsp_tag;
  assign op_count   = r_op_count;

endmodule

`default_nettype wire
